// File: rtl/banked_ram_pkg.sv
// Shared types and address mapping for the banked work RAM.
// Provides bank_t, the clear FSM state_t and the window-to-physical mapper.
package banked_ram_pkg;

    localparam int BANK_MAX_W = 8;

    // Bank value as seen on the 8-bit bank read-back port.
    typedef logic [BANK_MAX_W-1:0] bank_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // Upper half of the window is redirected to the selected bank,
    // lower half is always bank 0. Callers size-cast the result.
    function automatic logic [31:0] eff_addr(
        input logic [31:0] win_addr,
        input logic [31:0] bank,
        input int          win_w
    );
        logic [31:0] off;
        logic [31:0] base;
        off  = win_addr & ((32'd1 << (win_w - 1)) - 32'd1);
        base = win_addr[win_w-1] ? bank : 32'd0;
        return (base << (win_w - 1)) | off;
    endfunction

endpackage

// File: rtl/banked_ram_dp.sv
// Inferred simple dual-port byte RAM: port A read/write, port B read-only.
// Both read ports are registered and return the pre-write contents.
module banked_ram_dp #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [7:0]        a_wdata_i,
    output logic [7:0]        a_rdata_o,
    input  logic [ADDR_W-1:0] b_addr_i,
    output logic [7:0]        b_rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] a_rdata_q;
    logic [7:0] b_rdata_q;

    always_ff @(posedge clk) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        a_rdata_q <= mem_q[a_addr_i];
        b_rdata_q <= mem_q[b_addr_i];
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/banked_ram.sv
// Banked work RAM: fixed low half, bank-switched upper half, DMA read port.
// Ports: clk/reset, cpu_en, cgb, addr, wdata, write, rdata, switch_bank,
// bank_rdata, dma_req, dma_addr, dma_valid, dma_rdata, busy.
// Build option BANKED_RAM_CLEAR_EN adds a post-reset zero-fill FSM.
module banked_ram
    import banked_ram_pkg::*;
#(
    parameter int WIN_W      = 13,
    parameter int BANK_W     = 3,
    parameter int ZERO_REMAP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_en,
    input  logic             cgb,
    input  logic [WIN_W-1:0] addr,
    input  logic [7:0]       wdata,
    input  logic             write,
    output logic [7:0]       rdata,
    input  logic             switch_bank,
    output logic [7:0]       bank_rdata,
    input  logic             dma_req,
    input  logic [WIN_W-1:0] dma_addr,
    output logic             dma_valid,
    output logic [7:0]       dma_rdata,
    output logic             busy
);

    localparam int ADDR_W = BANK_W + WIN_W - 1;

    logic [BANK_W-1:0] bank_q, bank_d;
    logic              wprev_q;
    logic              rd_ok_q;
    logic              dv_q;

    logic              bank_we;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_ea;
    logic [ADDR_W-1:0] dma_ea;

    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [7:0]        a_wdata;
    logic [7:0]        a_rdata;
    logic [7:0]        b_rdata;

    assign cpu_ea = ADDR_W'(eff_addr(32'(addr), 32'(bank_q), WIN_W));
    assign dma_ea = ADDR_W'(eff_addr(32'(dma_addr), 32'(bank_q), WIN_W));

    // Rising edge of the write level only; a level held across reset
    // is blocked because wprev_q resets high.
    assign cpu_we  = write & ~wprev_q & ~busy;
    assign bank_we = cpu_en & switch_bank & cgb & ~busy;

    always_comb begin
        bank_d = bank_q;
        if (bank_we) begin
            bank_d = wdata[BANK_W-1:0];
            if (ZERO_REMAP != 0 && bank_d == '0) begin
                bank_d = BANK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_q  <= BANK_W'(1);
            wprev_q <= 1'b1;
            rd_ok_q <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            bank_q  <= bank_d;
            wprev_q <= write;
            rd_ok_q <= ~busy;
            dv_q    <= dma_req & ~busy;
        end
    end

`ifdef BANKED_RAM_CLEAR_EN
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
        endcase
    end

    // While clearing, port A is owned by the zero-fill sweep.
    always_comb begin
        busy    = (state_q == CLEAR);
        a_we    = cpu_we;
        a_addr  = cpu_ea;
        a_wdata = wdata;
        if (state_q == CLEAR) begin
            a_we    = 1'b1;
            a_addr  = cnt_q;
            a_wdata = 8'h00;
        end
    end
`else
    assign busy    = 1'b0;
    assign a_we    = cpu_we;
    assign a_addr  = cpu_ea;
    assign a_wdata = wdata;
`endif

    banked_ram_dp #(
        .ADDR_W(ADDR_W)
    ) u_dp (
        .clk      (clk),
        .a_we_i   (a_we),
        .a_addr_i (a_addr),
        .a_wdata_i(a_wdata),
        .a_rdata_o(a_rdata),
        .b_addr_i (dma_ea),
        .b_rdata_o(b_rdata)
    );

    // Outputs read as zero after reset, while clearing and when idle.
    assign rdata      = rd_ok_q ? a_rdata : 8'h00;
    assign dma_valid  = dv_q;
    assign dma_rdata  = dv_q ? b_rdata : 8'h00;
    assign bank_rdata = bank_t'(bank_q);

endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram: behavioural memory/bank model,
// per-cycle output compare, directed literal checks and random traffic.
module tb_banked_ram;

`ifdef BANKED_RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    localparam int NWORDS = 8 * 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_en = 1'b0;
    logic        cgb = 1'b1;
    logic [12:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        write = 1'b0;
    logic [7:0]  rdata;
    logic        switch_bank = 1'b0;
    logic [7:0]  bank_rdata;
    logic        dma_req = 1'b0;
    logic [12:0] dma_addr = '0;
    logic        dma_valid;
    logic [7:0]  dma_rdata;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    banked_ram dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_en     (cpu_en),
        .cgb        (cgb),
        .addr       (addr),
        .wdata      (wdata),
        .write      (write),
        .rdata      (rdata),
        .switch_bank(switch_bank),
        .bank_rdata (bank_rdata),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_valid  (dma_valid),
        .dma_rdata  (dma_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] mem_m [NWORDS];
    bit         known_m [NWORDS];
    int         bank_m = 1;
    bit         wprev_m = 1'b1;
    int         left_m = 0;
    bit         model_ok = 1'b0;
    int         exp_rd = 0, exp_dd = 0;
    bit         rk = 1'b1, dk = 1'b1, exp_dv = 1'b0, exp_busy = 1'b0;

    function automatic int phys(input int a, input int b);
        return (a >= 4096) ? b * 4096 + (a % 4096) : a;
    endfunction

    always @(posedge clk) begin
        int ea, da;
        bit bz;
        if (reset) begin
            bank_m   = 1;
            wprev_m  = 1'b1;
            exp_rd   = 0;
            rk       = 1'b1;
            exp_dv   = 1'b0;
            exp_dd   = 0;
            dk       = 1'b1;
            model_ok = 1'b1;
            if (CLR) begin
                left_m = NWORDS;
                for (int i = 0; i < NWORDS; i++) begin
                    mem_m[i]   = 8'h00;
                    known_m[i] = 1'b1;
                end
            end
        end else begin
            bz = (left_m != 0);
            ea = phys(int'(addr), bank_m);
            da = phys(int'(dma_addr), bank_m);
            if (bz) begin
                exp_rd = 0;
                rk     = 1'b1;
            end else begin
                exp_rd = int'(mem_m[ea]);
                rk     = known_m[ea];
            end
            exp_dv = dma_req && !bz;
            if (exp_dv) begin
                exp_dd = int'(mem_m[da]);
                dk     = known_m[da];
            end else begin
                exp_dd = 0;
                dk     = 1'b1;
            end
            if (write && !wprev_m && !bz) begin
                mem_m[ea]   = wdata;
                known_m[ea] = 1'b1;
                rk          = 1'b0;
            end
            if (cpu_en && switch_bank && cgb && !bz) begin
                bank_m = int'(wdata) % 8;
                if (bank_m == 0) bank_m = 1;
            end
            wprev_m = write;
            if (left_m > 0) left_m--;
        end
        exp_busy = (left_m != 0);
    end

    task automatic check(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            check("busy", int'(busy), int'(exp_busy));
            check("bank_rdata", int'(bank_rdata), bank_m);
            check("dma_valid", int'(dma_valid), int'(exp_dv));
            if (dk) check("dma_rdata", int'(dma_rdata), exp_dd);
            if (rk) check("rdata", int'(rdata), exp_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cpu_wr(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic set_bank(input logic [7:0] v, input logic g);
        @(negedge clk);
        wdata       = v;
        cgb         = g;
        cpu_en      = 1'b1;
        switch_bank = 1'b1;
        @(negedge clk);
        switch_bank = 1'b0;
        cgb         = 1'b1;
    endtask

    task automatic rd_lit(input string nm, input logic [12:0] a,
                          input int exp);
        @(negedge clk);
        addr = a;
        @(negedge clk);
        check(nm, int'(rdata), exp);
    endtask

    initial begin
        int n;
        @(negedge clk);
        reset = 1'b0;
        check("rst_bank", int'(bank_rdata), 1);
        check("rst_rdata", int'(rdata), 0);
        check("rst_dvalid", int'(dma_valid), 0);
        check("rst_ddata", int'(dma_rdata), 0);
        check("rst_busy", int'(busy), int'(CLR));

        if (CLR) begin
            repeat (1000) @(negedge clk);
            pulse_reset();
            n = 0;
            while (busy && n < 40000) begin
                if (n == 20000) begin
                    addr  = 13'h0030;
                    wdata = 8'h99;
                    write = 1'b1;
                end
                if (n == 20001) write = 1'b0;
                n++;
                @(negedge clk);
            end
            check("busy_len", n, NWORDS);
            rd_lit("clr_1fff", 13'h1FFF, 0);
            check("clr_bank", int'(bank_rdata), 1);
            rd_lit("clr_drop", 13'h0030, 0);
        end

        cpu_wr(13'h1000, 8'h5A);
        set_bank(8'h03, 1'b1);
        cpu_wr(13'h1000, 8'hA5);
        rd_lit("b3_1000", 13'h1000, 8'hA5);
        set_bank(8'h01, 1'b1);
        rd_lit("b1_1000", 13'h1000, 8'h5A);
        cpu_wr(13'h0000, 8'h3C);
        set_bank(8'h03, 1'b1);
        rd_lit("fixed_lo", 13'h0000, 8'h3C);
        set_bank(8'h00, 1'b1);
        check("remap0", int'(bank_rdata), 1);
        set_bank(8'h05, 1'b0);
        check("cgb_off", int'(bank_rdata), 1);

        @(negedge clk);
        addr  = 13'h0010;
        wdata = 8'h11;
        write = 1'b1;
        @(negedge clk) wdata = 8'h22;
        @(negedge clk) wdata = 8'h33;
        @(negedge clk) wdata = 8'h44;
        @(negedge clk) write = 1'b0;
        rd_lit("held_wr", 13'h0010, 8'h11);

        cpu_wr(13'h0020, 8'h00);
        @(negedge clk);
        addr     = 13'h0020;
        wdata    = 8'h77;
        write    = 1'b1;
        dma_req  = 1'b1;
        dma_addr = 13'h0020;
        @(negedge clk);
        write = 1'b0;
        check("coll_valid", int'(dma_valid), 1);
        check("coll_old", int'(dma_rdata), 8'h00);
        @(negedge clk);
        check("b2b_valid", int'(dma_valid), 1);
        check("coll_new", int'(dma_rdata), 8'h77);
        dma_req = 1'b0;
        @(negedge clk);
        check("dma_idle", int'(dma_valid), 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            addr        = 13'((32'($urandom_range(0, 1)) << 12)
                              | 32'($urandom_range(0, 15)));
            dma_addr    = 13'((32'($urandom_range(0, 1)) << 12)
                              | 32'($urandom_range(0, 15)));
            wdata       = 8'($urandom);
            write       = ($urandom_range(0, 2) == 0);
            switch_bank = ($urandom_range(0, 9) == 0);
            cgb         = ($urandom_range(0, 7) != 0);
            cpu_en      = ($urandom_range(0, 5) != 0);
            dma_req     = ($urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        write       = 1'b0;
        switch_bank = 1'b0;
        dma_req     = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
